button_event_arbiter: RTL and testbench

// - Turns N debounced button levels into a serialized stream of press events.
// - Detects rising edges and latches one pending flag per channel.
// - Round-robin arbitration feeds one output register with a valid/ready handshake.
// - Sits between the per-button debouncers and the CPU input/IO logic.

---
 rtl/button_event_arbiter_if.sv | 26 ++
 rtl/button_event_arbiter.sv | 135 +++++++++++++
 tb/tb_button_event_arbiter.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/button_event_arbiter_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : button_event_arbiter_if                                |
// | Brief   : valid/ready event channel carrying a button channel id |
// | Revision: 1.0  initial release                                   |
// +------------------------------------------------------------------+
interface button_event_arbiter_if #(
   parameter int ID_W = 2
);
   logic            evt_valid;
   logic            evt_ready;
   logic [ID_W-1:0] evt_id;

   modport master (
      output evt_valid,
      output evt_id,
      input  evt_ready
   );

   modport slave (
      input  evt_valid,
      input  evt_id,
      output evt_ready
   );
endinterface
`default_nettype wire

// File: rtl/button_event_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : button_event_arbiter                                   |
// | Brief   : rising-edge press capture with round-robin event       |
// |           serialisation; AUTO_REPEAT_EN adds held-key repeats    |
// | Revision: 1.0  initial release                                   |
// +------------------------------------------------------------------+
module button_event_arbiter #(
   parameter int N             = 4,
   parameter int ID_W          = 2,
   parameter int RPT_W         = 8,
   parameter int REPEAT_DELAY  = 200,
   parameter int REPEAT_PERIOD = 50
) (
   input  wire logic                  clk,
   input  wire logic                  rst_n,
   input  wire logic [N-1:0]          i_btn_db,
   input  wire logic                  i_ovr_clr,
   output logic                       o_overrun,
   button_event_arbiter_if.master     evt_if
);

   localparam logic [ID_W-1:0] c_LAST = ID_W'(N - 1);

   if (N < 1 || N > 16 || N > (1 << ID_W)) begin : g_bad_n
      $error("button_event_arbiter: N out of range for ID_W");
   end
   if (REPEAT_DELAY < 2 || REPEAT_DELAY >= (1 << RPT_W) ||
       REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY) begin : g_bad_rpt
      $error("button_event_arbiter: repeat timing out of range");
   end

   logic [N-1:0]    r_prev;
   logic [N-1:0]    r_pend;
   logic [ID_W-1:0] r_ptr;
   logic            r_valid;
   logic [ID_W-1:0] r_id;
   logic            r_ovr;

   logic [N-1:0]    w_rise;
   logic [N-1:0]    w_set;
   logic [N-1:0]    w_onehot;
   logic [N-1:0]    w_grant;
   logic [ID_W-1:0] w_winner;
   logic [ID_W-1:0] w_ptr_nxt;
   logic            w_found;
   logic            w_load;

   assign w_rise = i_btn_db & ~r_prev;

`ifdef AUTO_REPEAT_EN
   localparam logic [RPT_W-1:0] c_RPT_FIRE   = RPT_W'(REPEAT_DELAY - 1);
   localparam logic [RPT_W-1:0] c_RPT_RELOAD = RPT_W'(REPEAT_DELAY - REPEAT_PERIOD);

   logic [N-1:0] w_rep;

   // Reloading to DELAY-PERIOD after each fire keeps the count below DELAY,
   // so it never wraps however long the button is held.
   for (genvar g = 0; g < N; g++) begin : g_rpt
      logic [RPT_W-1:0] r_cnt;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_cnt <= '0;
         end else if (w_rise[g] || !i_btn_db[g]) begin
            r_cnt <= '0;
         end else if (r_cnt == c_RPT_FIRE) begin
            r_cnt <= c_RPT_RELOAD;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end

      assign w_rep[g] = i_btn_db[g] & ~w_rise[g] & (r_cnt == c_RPT_FIRE);
   end

   assign w_set = w_rise | w_rep;
`else
   assign w_set = w_rise;
`endif

   // Two passes: channels at or above the pointer first, then wrap to the rest.
   always_comb begin
      w_found  = 1'b0;
      w_winner = '0;
      w_onehot = '0;
      for (int j = 0; j < N; j++) begin
         if (!w_found && r_pend[j] && (j >= int'(r_ptr))) begin
            w_found     = 1'b1;
            w_winner    = ID_W'(j);
            w_onehot[j] = 1'b1;
         end
      end
      for (int j = 0; j < N; j++) begin
         if (!w_found && r_pend[j]) begin
            w_found     = 1'b1;
            w_winner    = ID_W'(j);
            w_onehot[j] = 1'b1;
         end
      end
   end

   assign w_load    = (~r_valid | evt_if.evt_ready) & w_found;
   assign w_grant   = {N{w_load}} & w_onehot;
   assign w_ptr_nxt = (w_winner == c_LAST) ? '0 : w_winner + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prev  <= '0;
         r_pend  <= '0;
         r_ptr   <= '0;
         r_valid <= 1'b0;
         r_id    <= '0;
         r_ovr   <= 1'b0;
      end else begin
         r_prev <= i_btn_db;
         // A new press on a channel being granted this cycle stays queued.
         r_pend <= w_set | (r_pend & ~w_grant);
         r_ovr  <= (|(w_set & r_pend & ~w_grant)) | (r_ovr & ~i_ovr_clr);
         if (w_load) begin
            r_valid <= 1'b1;
            r_id    <= w_winner;
            r_ptr   <= w_ptr_nxt;
         end else if (evt_if.evt_ready) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign evt_if.evt_valid = r_valid;
   assign evt_if.evt_id    = r_id;
   assign o_overrun        = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_button_event_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : tb_button_event_arbiter                                |
// | Brief   : directed self-checking bench for button_event_arbiter  |
// | Revision: 1.0  initial release                                   |
// +------------------------------------------------------------------+
module tb_button_event_arbiter;

   localparam int c_N    = 4;
   localparam int c_ID_W = 2;
`ifdef AUTO_REPEAT_EN
   localparam int c_RD = 16;
   localparam int c_RP = 4;
`else
   localparam int c_RD = 200;
   localparam int c_RP = 50;
`endif

   logic           clk     = 1'b0;
   logic           rst_n   = 1'b0;
   logic [c_N-1:0] btn_db  = '0;
   logic           ovr_clr = 1'b0;
   logic           overrun;

   int n_cmp = 0;
   int n_err = 0;
   int n_acc;
   int acc_q[$];

   button_event_arbiter_if #(.ID_W(c_ID_W)) evt_if ();

   button_event_arbiter #(
      .N             (c_N),
      .ID_W          (c_ID_W),
      .RPT_W         (8),
      .REPEAT_DELAY  (c_RD),
      .REPEAT_PERIOD (c_RP)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_btn_db  (btn_db),
      .i_ovr_clr (ovr_clr),
      .o_overrun (overrun),
      .evt_if    (evt_if)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset;
      rst_n            = 1'b0;
      btn_db           = '0;
      ovr_clr          = 1'b0;
      evt_if.evt_ready = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      evt_if.evt_ready = 1'b0;
      btn_db           = 4'($urandom);
      repeat (3) tick();
      check_eq("rst_valid", 32'(evt_if.evt_valid), 0);
      check_eq("rst_id", 32'(evt_if.evt_id), 0);
      check_eq("rst_ovr", 32'(overrun), 0);
      btn_db = '0;
      rst_n  = 1'b1;

      // single press: visible two cycles after the input change, for one cycle
      evt_if.evt_ready = 1'b1;
      btn_db           = 4'b0100;
      tick();
      check_eq("single_lat1", 32'(evt_if.evt_valid), 0);
      btn_db = '0;
      tick();
      check_eq("single_valid", 32'(evt_if.evt_valid), 1);
      check_eq("single_id", 32'(evt_if.evt_id), 2);
      tick();
      check_eq("single_drop", 32'(evt_if.evt_valid), 0);

      // simultaneous press from ptr=0
      do_reset();
      evt_if.evt_ready = 1'b1;
      btn_db           = 4'b1011;
      tick();
      check_eq("simul_lat1", 32'(evt_if.evt_valid), 0);
      btn_db = '0;
      tick();
      check_eq("simul_v0", 32'(evt_if.evt_valid), 1);
      check_eq("simul_id0", 32'(evt_if.evt_id), 0);
      tick();
      check_eq("simul_v1", 32'(evt_if.evt_valid), 1);
      check_eq("simul_id1", 32'(evt_if.evt_id), 1);
      tick();
      check_eq("simul_v2", 32'(evt_if.evt_valid), 1);
      check_eq("simul_id3", 32'(evt_if.evt_id), 3);
      tick();
      check_eq("simul_end", 32'(evt_if.evt_valid), 0);
      btn_db = 4'b0001;
      tick();
      btn_db = '0;
      tick();
      check_eq("wrap_valid", 32'(evt_if.evt_valid), 1);
      check_eq("wrap_id", 32'(evt_if.evt_id), 0);
      tick();
      check_eq("wrap_end", 32'(evt_if.evt_valid), 0);

      // backpressure: three presses of ch1 while the consumer stalls
      evt_if.evt_ready = 1'b0;
      for (int p = 0; p < 3; p++) begin
         btn_db = 4'b0010;
         tick();
         btn_db = '0;
         tick();
         check_eq($sformatf("bp_valid%0d", p), 32'(evt_if.evt_valid), 1);
         check_eq($sformatf("bp_id%0d", p), 32'(evt_if.evt_id), 1);
         check_eq($sformatf("bp_ovr%0d", p), 32'(overrun), (p == 2) ? 1 : 0);
      end
      evt_if.evt_ready = 1'b1;
      n_acc = 0;
      for (int c = 0; c < 4; c++) begin
         if (evt_if.evt_valid && evt_if.evt_ready) begin
            n_acc++;
            check_eq("bp_drain_id", 32'(evt_if.evt_id), 1);
         end
         tick();
      end
      check_eq("bp_drain_cnt", 32'(n_acc), 2);
      check_eq("bp_ovr_sticky", 32'(overrun), 1);
      ovr_clr = 1'b1;
      tick();
      ovr_clr = 1'b0;
      check_eq("bp_ovr_clr", 32'(overrun), 0);

      // asynchronous reset while an event is held
      evt_if.evt_ready = 1'b0;
      btn_db           = 4'b0100;
      tick();
      btn_db = '0;
      tick();
      check_eq("arst_pre", 32'(evt_if.evt_valid), 1);
      #2 rst_n = 1'b0;
      #1;
      check_eq("arst_valid", 32'(evt_if.evt_valid), 0);
      check_eq("arst_id", 32'(evt_if.evt_id), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // round-robin fairness: chs 0 and 3 every 4 cycles, ready toggling
      for (int c = 0; c < 16; c++) begin
         btn_db           = ((c % 4) == 0) ? 4'b1001 : 4'b0000;
         evt_if.evt_ready = ((c % 2) == 0);
         if (evt_if.evt_valid && evt_if.evt_ready) acc_q.push_back(int'(evt_if.evt_id));
         tick();
      end
      check_eq("rr_count", 32'(acc_q.size() >= 4), 1);
      for (int i = 0; i < 4 && i < acc_q.size(); i++) begin
         check_eq($sformatf("rr_grant%0d", i), 32'(acc_q[i]), ((i % 2) == 0) ? 0 : 3);
      end
      check_eq("rr_ovr", 32'(overrun), 0);
      btn_db           = '0;
      evt_if.evt_ready = 1'b1;
      tick();
      tick();

`ifdef AUTO_REPEAT_EN
      // held ch0 for 30 cycles: events at +2, +18, +22, +26, +30
      do_reset();
      evt_if.evt_ready = 1'b1;
      btn_db           = 4'b0001;
      for (int s = 1; s <= 40; s++) begin
         tick();
         if (s == 30) btn_db = '0;
         check_eq($sformatf("rpt_s%0d", s), 32'(evt_if.evt_valid),
                  (s == 2 || s == 18 || s == 22 || s == 26 || s == 30) ? 1 : 0);
      end
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
